// File: rtl/seq_pkg.sv
// Shared definitions for the serial pattern transmitter and detector blocks.
// Holds the FSM state encoding, default sizes and a counter-width helper.
package seq_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        GAP_WAIT,
        DONE
    } state_t;

    localparam int SEQ_SIZE     = 4;
    localparam int SEQ_GAP      = 2;
    localparam int SEQ_REPEAT_W = 4;

    // Width needed to hold values 0..n-1, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/seq_piso.sv
// Parallel-in serial-out shift register, MSB first.
// Load has priority over shift; vacated LSBs fill with zero.
module seq_piso #(
    parameter int SIZE = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            load,
    input  logic            shift,
    input  logic [SIZE-1:0] din,
    output logic            msb
);

    logic [SIZE-1:0] q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= '0;
        end else if (load) begin
            q <= din;
        end else if (shift) begin
            q <= {q[SIZE-2:0], 1'b0};
        end
    end

    assign msb = q[SIZE-1];

endmodule

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: sends a captured pattern MSB-first,
// repeat_cnt+1 times, with GAP idle cycles between frames.
module seq_pattern_tx
    import seq_pkg::*;
#(
    parameter int SIZE     = SEQ_SIZE,
    parameter int REPEAT_W = SEQ_REPEAT_W,
    parameter int GAP      = SEQ_GAP
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                abort,
    input  logic [SIZE-1:0]     pattern,
    input  logic [REPEAT_W-1:0] repeat_cnt,
    output logic                ready,
    output logic                out,
    output logic                out_valid,
    output logic                frame_start,
    output logic                done
);

    localparam int BW = cnt_w(SIZE);
    localparam int GW = cnt_w(GAP + 1);

    state_t              state;
    logic [BW-1:0]       bit_idx;
    logic [REPEAT_W-1:0] fcnt;
    logic [GW-1:0]       gcnt;
    logic [SIZE-1:0]     pat_q;

    logic            last_bit;
    logic            gap_last;
    logic            more;
    logic            piso_load;
    logic            piso_shift;
    logic [SIZE-1:0] piso_din;
    logic            piso_msb;

    assign last_bit = (bit_idx == BW'(SIZE - 1));
    assign gap_last = (gcnt == GW'(GAP - 1));
    assign more     = (fcnt != '0);

    // Shift register control mirrors the FSM transitions below.
    always_comb begin
        piso_load  = 1'b0;
        piso_shift = 1'b0;
        piso_din   = pat_q;
        unique case (state)
            IDLE: begin
                if (start && !abort) begin
                    piso_load = 1'b1;
                    piso_din  = pattern;
                end
            end
            SEND: begin
                if (!abort) begin
                    if (last_bit && more && GAP == 0) begin
                        piso_load = 1'b1;
                    end else begin
                        piso_shift = 1'b1;
                    end
                end
            end
            GAP_WAIT: begin
                if (!abort && gap_last) begin
                    piso_load = 1'b1;
                end
            end
            default: ;
        endcase
    end

    seq_piso #(
        .SIZE(SIZE)
    ) u_piso (
        .clk  (clk),
        .reset(reset),
        .load (piso_load),
        .shift(piso_shift),
        .din  (piso_din),
        .msb  (piso_msb)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            bit_idx <= '0;
            fcnt    <= '0;
            gcnt    <= '0;
            pat_q   <= '0;
        end else if (abort && state != IDLE) begin
            state <= IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start && !abort) begin
                        pat_q   <= pattern;
                        fcnt    <= repeat_cnt;
                        bit_idx <= '0;
                        state   <= SEND;
                    end
                end
                SEND: begin
                    bit_idx <= bit_idx + 1'b1;
                    if (last_bit) begin
                        bit_idx <= '0;
                        if (!more) begin
                            state <= DONE;
                        end else begin
                            fcnt <= fcnt - 1'b1;
                            if (GAP == 0) begin
                                state <= SEND;
                            end else begin
                                gcnt  <= '0;
                                state <= GAP_WAIT;
                            end
                        end
                    end
                end
                GAP_WAIT: begin
                    if (gap_last) begin
                        bit_idx <= '0;
                        state   <= SEND;
                    end else begin
                        gcnt <= gcnt + 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign ready       = (state == IDLE);
    assign out_valid   = (state == SEND);
    assign out         = out_valid & piso_msb;
    assign frame_start = out_valid && (bit_idx == '0);
    assign done        = (state == DONE);

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Self-checking bench for seq_pattern_tx: a GAP=2 and a GAP=0 instance,
// per-cycle expectations queued at start and popped as cycles elapse.
module tb_seq_pattern_tx;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic       st2, ab2, st0, ab0;
    logic [3:0] pat2, rc2, pat0, rc0;
    logic       r2, o2, v2, f2, d2;
    logic       r0, o0, v0, f0, d0;

    int checks = 0;
    int errors = 0;

    logic [4:0] exp_q[$];

    seq_pattern_tx #(.SIZE(4), .REPEAT_W(4), .GAP(2)) u_g2 (
        .clk(clk), .reset(reset), .start(st2), .abort(ab2),
        .pattern(pat2), .repeat_cnt(rc2), .ready(r2), .out(o2),
        .out_valid(v2), .frame_start(f2), .done(d2)
    );

    seq_pattern_tx #(.SIZE(4), .REPEAT_W(4), .GAP(0)) u_g0 (
        .clk(clk), .reset(reset), .start(st0), .abort(ab0),
        .pattern(pat0), .repeat_cnt(rc0), .ready(r0), .out(o0),
        .out_valid(v0), .frame_start(f0), .done(d0)
    );

    // Moore 1011 detector fed by the GAP=0 instance, gated by out_valid.
    logic [2:0] hist;
    logic       det;
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            hist <= '0;
            det  <= 1'b0;
        end else begin
            det <= v0 && ({hist, o0} == 4'b1011);
            if (v0) hist <= {hist[1:0], o0};
        end
    end

    // {ready, out_valid, out, frame_start, done}
    function automatic logic [4:0] obs(input bit g0);
        return g0 ? {r0, v0, o0, f0, d0} : {r2, v2, o2, f2, d2};
    endfunction

    task automatic set_in(input bit g0, input logic st, input logic ab,
                          input logic [3:0] p, input logic [3:0] rc);
        if (g0) begin
            st0 = st; ab0 = ab; pat0 = p; rc0 = rc;
        end else begin
            st2 = st; ab2 = ab; pat2 = p; rc2 = rc;
        end
    endtask

    task automatic gen_expect(input bit g0, input logic [3:0] p,
                              input logic [3:0] rc);
        int gap = g0 ? 0 : 2;
        int nf = int'(rc) + 1;
        int per = 4 + gap;
        int last = nf * 4 + (nf - 1) * gap;
        for (int c = 1; c <= last + 2; c++) begin
            int k = c - 1;
            int f = k / per;
            int i = k % per;
            logic v = (f < nf) && (i < 4);
            logic o = v ? p[3 - i] : 1'b0;
            exp_q.push_back({c == last + 2, v, o, v && i == 0, c == last + 1});
        end
    endtask

    task automatic wait_ready(input bit g0);
        int n = 0;
        @(negedge clk);
        while (!obs(g0)[4] && n < 60) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!obs(g0)[4]) begin
            errors++;
            $display("FAIL wait_ready: ready=0 after %0d cycles, required 1", n);
        end
    endtask

    task automatic run_xfer(input bit g0, input logic [3:0] p,
                            input logic [3:0] rc, input bit chk_det);
        int c = 0;
        logic [4:0] e;
        logic [4:0] a;
        wait_ready(g0);
        gen_expect(g0, p, rc);
        set_in(g0, 1'b1, 1'b0, p, rc);
        @(posedge clk);
        while (exp_q.size() > 0) begin
            @(negedge clk);
            c++;
            set_in(g0, 1'b0, 1'b0, ~p, ~rc);
            e = exp_q.pop_front();
            a = obs(g0);
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL xfer g0=%0d pat=%b rc=%0d cyc=%0d: got %b required %b",
                         g0, p, rc, c, a, e);
            end
            if (chk_det) begin
                logic ed = (c >= 5) && (c <= 17) && (c % 4 == 1);
                checks++;
                if (det !== ed) begin
                    errors++;
                    $display("FAIL loopback det cyc=%0d: got %b required %b", c, det, ed);
                end
            end
        end
    endtask

    task automatic test_reset;
        @(negedge clk);
        checks++;
        if (obs(0) !== 5'b10000 || obs(1) !== 5'b10000) begin
            errors++;
            $display("FAIL reset_state: got %b/%b required 10000", obs(0), obs(1));
        end
        reset = 1'b0;
    endtask

    task automatic test_single;
        run_xfer(1'b0, 4'b1011, 4'd0, 1'b0);
    endtask

    task automatic test_repeat;
        run_xfer(1'b0, 4'b1011, 4'd2, 1'b0);
    endtask

    task automatic test_back_to_back;
        run_xfer(1'b1, 4'b1001, 4'd1, 1'b0);
    endtask

    task automatic test_abort;
        logic [4:0] e;
        wait_ready(1'b0);
        gen_expect(1'b0, 4'b1011, 4'd2);
        set_in(1'b0, 1'b1, 1'b0, 4'b1011, 4'd2);
        @(posedge clk);
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if (obs(0) !== e) begin
                errors++;
                $display("FAIL abort_pre cyc=%0d: got %b required %b", c, obs(0), e);
            end
            set_in(1'b0, c <= 4, c == 6, 4'b0110, 4'd5);
        end
        exp_q.delete();
        @(posedge clk);
        for (int c = 7; c <= 20; c++) begin
            @(negedge clk);
            set_in(1'b0, 1'b0, 1'b0, 4'b0000, 4'd0);
            checks++;
            if (obs(0) !== 5'b10000) begin
                errors++;
                $display("FAIL abort_idle cyc=%0d: got %b required 10000", c, obs(0));
            end
        end
    endtask

    task automatic test_abort_in_idle;
        wait_ready(1'b0);
        set_in(1'b0, 1'b1, 1'b1, 4'b1111, 4'd0);
        @(posedge clk);
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            set_in(1'b0, 1'b0, c == 1, 4'b1111, 4'd0);
            checks++;
            if (obs(0) !== 5'b10000) begin
                errors++;
                $display("FAIL abort_wins cyc=%0d: got %b required 10000", c, obs(0));
            end
        end
    endtask

    task automatic test_reset_mid_send;
        wait_ready(1'b0);
        set_in(1'b0, 1'b1, 1'b0, 4'b1011, 4'd0);
        @(posedge clk);
        @(negedge clk);
        set_in(1'b0, 1'b0, 1'b0, 4'b1011, 4'd0);
        checks++;
        if (obs(0) !== 5'b01110) begin
            errors++;
            $display("FAIL mid_reset_bit0: got %b required 01110", obs(0));
        end
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b1;
        #1;
        checks++;
        if ({r2, v2, o2} !== 3'b100) begin
            errors++;
            $display("FAIL mid_reset_same_cycle: got %b required 100", {r2, v2, o2});
        end
        @(negedge clk);
        reset = 1'b0;
        run_xfer(1'b0, 4'b0110, 4'd0, 1'b0);
    endtask

    task automatic test_loopback;
        run_xfer(1'b1, 4'b1011, 4'd3, 1'b1);
    endtask

    initial begin
        set_in(1'b0, 1'b0, 1'b0, 4'b0000, 4'd0);
        set_in(1'b1, 1'b0, 1'b0, 4'b0000, 4'd0);
        @(negedge clk);
        test_reset;
        test_single;
        test_repeat;
        test_back_to_back;
        test_abort;
        test_abort_in_idle;
        test_reset_mid_send;
        test_loopback;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/seq_pattern_tx.md
# seq_pattern_tx

Serial pattern transmitter: the transmit-side counterpart of the team's Moore sequence detectors. It captures a SIZE-bit pattern on a start handshake and drives it MSB-first onto a one-bit serial line, repeated a programmable number of times with a fixed idle gap between frames. It sits in front of a detector, either in loopback test benches or as the stimulus source on the serial path. All outputs are Moore outputs, decoded from state and registers only.

## Interface
- SIZE, 4: pattern width in bits, at least 2.
- REPEAT_W, 4: width of the repeat-count input.
- GAP, 2: idle cycles between consecutive frames; 0 means back-to-back frames.
- clk  in  1  clock, rising edge.
- reset  in  1  reset, asynchronous, active-high.
- start  in  1  request; accepted only while ready=1.
- abort  in  1  synchronous cancel of an active transfer.
- pattern  in  SIZE  bits to send; captured when start is accepted.
- repeat_cnt  in  REPEAT_W  extra frames; frames sent = repeat_cnt+1.
- ready  out  1  high only in IDLE.
- out  out  1  serial data; 0 whenever out_valid=0.
- out_valid  out  1  high while a pattern bit is on out.
- frame_start  out  1  high during the first bit of every frame.
- done  out  1  one-cycle pulse after the last bit of the last frame.

## Operation
- States: IDLE, SEND, GAP_WAIT, DONE.
- IDLE:
  - ready=1.
  - start=1 and abort=0 at an edge: capture pattern into the shift register, capture repeat_cnt into the frame counter, clear the bit index, go to SEND.
- SEND:
  - out = current MSB of the shift register, out_valid=1.
  - frame_start=1 when bit index = 0.
  - Each edge: shift left by one and increment the bit index.
  - At bit index SIZE-1, choose the next state as follows:
    - Frame counter = 0: go to DONE.
    - Frame counter > 0 and GAP=0: decrement the counter, reload the captured pattern, stay in SEND.
    - Frame counter > 0 and GAP>0: decrement the counter, go to GAP_WAIT.
- GAP_WAIT:
  - out=0, out_valid=0.
  - Stay GAP cycles, then reload the pattern from the captured copy and go to SEND.
- DONE: done=1 for exactly one cycle, then go to IDLE.
- Input changes after capture:
  - pattern and repeat_cnt changes after capture have no effect on the transfer in progress.
  - start while ready=0 is ignored; it is not queued.
- abort:
  - abort=1 at an edge in SEND, GAP_WAIT or DONE: go to IDLE at that edge. No done pulse. out and out_valid drop in the following cycle.
  - abort=1 in IDLE is ignored. abort wins over a simultaneous start.
- Reset (asserted at any time, including mid-frame): immediately go to IDLE and clear all counters and the shift register. Reset values: ready=1, out=0, out_valid=0, frame_start=0, done=0.
- Width rules:
  - Bit index is $clog2(SIZE) bits.
  - The gap counter is $clog2(GAP+1) bits, with a minimum of 1 bit.
  - The frame counter is REPEAT_W bits and never wraps: it is decremented only when it is greater than 0.

## Timing
- Edge numbering: start accepted at edge E0; "cycle n" is the interval after edge E(n-1).
- Bit i of frame f (both counted from 0) is driven in cycle 1 + f*(SIZE+GAP) + i.
- For F = repeat_cnt+1 frames:
  - done is high in cycle F*SIZE + (F-1)*GAP + 1.
  - ready returns in the cycle after that.
- The earliest next start is accepted at the first edge where ready=1. Minimum start-to-start spacing is F*SIZE + (F-1)*GAP + 2 edges.
- No combinational path from any input to any output.

## Structure
- Package seq_pkg holds:
  - The state typedef: enum logic [1:0] {IDLE, SEND, GAP_WAIT, DONE}.
  - The default SIZE/GAP localparams, shared with the detector blocks.
- One sub-module, seq_piso:
  - Parallel-in serial-out shift register with load, shift and MSB output, parameterized by SIZE.
  - The FSM, bit counter, frame counter and gap counter stay in seq_pattern_tx.

## Test plan
- Reset mid-SEND: assert reset during the bit-2 cycle -> same cycle: ready=1, out_valid=0, out=0. After release, a new start of 4'b0110 produces out 0,1,1,0 in cycles 1-4.
- SIZE=4, GAP=2, pattern=4'b1011, repeat_cnt=0:
  - out = 1,0,1,1 in cycles 1-4, with frame_start only in cycle 1.
  - done in cycle 5, ready in cycle 6.
- Same pattern, repeat_cnt=2 (three frames):
  - Bits in cycles 1-4, 7-10 and 13-16; out_valid=0 in cycles 5-6 and 11-12.
  - frame_start in cycles 1, 7 and 13; done in cycle 17.
- GAP=0, pattern=4'b1001, repeat_cnt=1 -> out = 1,0,0,1,1,0,0,1 in cycles 1-8, out_valid continuously high, done in cycle 9.
- abort at the edge ending cycle 6 of the repeat_cnt=2 run -> IDLE in cycle 7, out_valid=0, no done pulse. A start held high while ready=0 produces no second transfer.
- Loopback: SIZE=4, pattern=4'b1011, repeat_cnt=3, GAP=0, out fed into the 1011 detector gated by out_valid -> the detector output asserts one cycle after each frame's last bit.
